gate_cfg_frame_tx: RTL and testbench
====================================

GATE_CFG_FRAME_TX -- requirements
Module: gate_cfg_frame_tx

Interface
REQ-001 SHALL have parameter IFG_CYCLES, default 4: idle cycles forced between frames (legal range 2..255).
REQ-002 SHALL have parameter HDR_BYTE, default 8'hBD: frame header byte.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port send_req, input, 1: one-cycle request to transmit one config frame.
REQ-006 SHALL have port delay_time, input, 32: gate open count, sampled when a request is accepted.
REQ-007 SHALL have port stop_time, input, 32: gate close count, sampled when a request is accepted.
REQ-008 SHALL have port data_out, output, 8: frame byte.
REQ-009 SHALL have port data_out_valid, output, 1: data_out qualifier.
REQ-010 SHALL have port last_data, output, 1: high with the final frame byte only.
REQ-011 SHALL have port busy, output, 1: high from request acceptance through the end of the gap.
REQ-012 SHALL have port frame_done, output, 1: one-cycle pulse, cycle after last_data.
REQ-013 SHALL have port cfg_err, output, 1: one-cycle pulse on a rejected request.
REQ-014 SHALL have port seq_num, output, 8: sequence number of the most recently sent frame.

Function
REQ-015 Frame SHALL be 16 bytes, indices 0..15, MSB-first fields.
- byte0 = HDR_BYTE.
- byte1 = seq_num+1.
- bytes2..4 = 8'h00.
- bytes5..8 = delay_time[31:24]..[7:0].
- bytes9..12 = stop_time[31:24]..[7:0].
- bytes13..14 = 8'h00.
- byte15 = XOR of bytes0..14.
REQ-016 Frame bytes SHALL be emitted on 16 consecutive cycles with data_out_valid continuously high; there is no mid-frame stall (the receiver byte counter free-runs once started).
REQ-017 FSM SHALL have states IDLE, SEND, GAP.
- IDLE->SEND on an accepted request.
- SEND->GAP after byte15.
- GAP->IDLE after IFG_CYCLES cycles, or GAP->SEND directly if a request is pending at gap end.
REQ-018 Request acceptance: send_req in IDLE SHALL be accepted; byte0 SHALL appear on data_out the cycle after send_req (latency 1).
REQ-019 send_req while busy SHALL set a one-deep pending flag and latch delay_time and stop_time into a shadow register; further requests while pending SHALL overwrite the shadow (last wins).
- A pending request SHALL start sending the cycle after the gap ends.
REQ-020 Validation: a request with stop_time <= delay_time or stop_time == 0 SHALL be rejected.
- cfg_err pulses the next cycle.
- No frame is sent and no pending flag is set.
- seq_num is unchanged.
REQ-021 seq_num SHALL update to byte1's value on the cycle byte15 is emitted, wrapping 8'hFF->8'h00.
REQ-022 When data_out_valid is low, data_out SHALL be 8'h00 and last_data SHALL be low.
REQ-023 busy SHALL be high during SEND and GAP, and SHALL be low in IDLE with no pending request.
REQ-024 Checksum SHALL be accumulated incrementally per byte, not recomputed combinationally over the whole frame.

Reset
REQ-025 While rst is high, the following SHALL be 0 at the next edge:
- state = IDLE.
- data_out, data_out_valid, last_data, busy, frame_done, cfg_err, pending flag.
- seq_num.
- Internal byte counter, gap counter and checksum.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately with no further bytes, and the pending request SHALL be discarded.
REQ-027 send_req coincident with rst SHALL be ignored.

Verification
REQ-028 After reset, send_req with delay_time=32'h00000050 and stop_time=32'h00000320 -> next 16 cycles emit BD 01 00 00 00 00 00 00 50 00 00 03 20 00 00 (XOR). last_data is high only on byte15, frame_done pulses one cycle later, and seq_num becomes 1.
REQ-029 Second send_req issued during frame 1, byte 7 -> frame 2 byte0 appears exactly IFG_CYCLES+1 cycles after frame 1 byte15, with byte1=02 and the shadowed values.
REQ-030 send_req with delay_time=100 and stop_time=100 -> cfg_err pulses once, data_out_valid stays 0, and seq_num is unchanged.
REQ-031 Three send_req while busy with stop_time 500, 600 and 700 -> exactly one follow-on frame, carrying 700.
REQ-032 rst asserted at byte 9 -> data_out_valid is 0 the next cycle, busy is 0, and a fresh send_req produces a frame with byte1=01.
REQ-033 256 back-to-back valid frames -> seq_num wraps to 00 and byte1 of frame 256 equals 00.

Source files
------------

// File: rtl/gate_cfg_frame_tx.sv
// Gate configuration frame transmitter: emits a fixed 16-byte frame carrying the
// gate open/close counts, enforces an inter-frame gap and buffers one pending request.
module gate_cfg_frame_tx #(
    parameter int unsigned IFG_CYCLES = 4,
    parameter logic [7:0]  HDR_BYTE   = 8'hBD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send_req,
    input  logic [31:0] delay_time,
    input  logic [31:0] stop_time,
    output logic [7:0]  data_out,
    output logic        data_out_valid,
    output logic        last_data,
    output logic        busy,
    output logic        frame_done,
    output logic        cfg_err,
    output logic [7:0]  seq_num
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned TIME_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned GAP_W  = 8;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(15);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [BYTE_W-1:0]   csum_q, csum_d;
    logic [BYTE_W-1:0]   seq_q, seq_d;
    logic [TIME_W-1:0]   frm_delay_q, frm_delay_d;
    logic [TIME_W-1:0]   frm_stop_q, frm_stop_d;
    logic [TIME_W-1:0]   shd_delay_q, shd_delay_d;
    logic [TIME_W-1:0]   shd_stop_q, shd_stop_d;
    logic                pend_q, pend_d;
    logic [BYTE_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                req_ok;
    logic                start;
    logic [TIME_W-1:0]   start_delay;
    logic [TIME_W-1:0]   start_stop;
    logic [BYTE_W-1:0]   cur_byte;

    // A request is legal only if the gate closes strictly after it opens.
    assign req_ok = send_req && (stop_time != '0) && (stop_time > delay_time);

    // Payload byte for the current index; index 15 takes the running checksum.
    always_comb begin
        cur_byte = 8'h00;
        case (byte_cnt_q)
            4'd1:    cur_byte = BYTE_W'(seq_q + 8'd1);
            4'd5:    cur_byte = frm_delay_q[31:24];
            4'd6:    cur_byte = frm_delay_q[23:16];
            4'd7:    cur_byte = frm_delay_q[15:8];
            4'd8:    cur_byte = frm_delay_q[7:0];
            4'd9:    cur_byte = frm_stop_q[31:24];
            4'd10:   cur_byte = frm_stop_q[23:16];
            4'd11:   cur_byte = frm_stop_q[15:8];
            4'd12:   cur_byte = frm_stop_q[7:0];
            4'd15:   cur_byte = csum_q;
            default: cur_byte = 8'h00;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        csum_d      = csum_q;
        seq_d       = seq_q;
        frm_delay_d = frm_delay_q;
        frm_stop_d  = frm_stop_q;
        shd_delay_d = shd_delay_q;
        shd_stop_d  = shd_stop_q;
        pend_d      = pend_q;
        data_d      = 8'h00;
        valid_d     = 1'b0;
        last_d      = 1'b0;
        done_d      = last_q;
        err_d       = send_req && !req_ok;
        start       = 1'b0;
        start_delay = delay_time;
        start_stop  = stop_time;

        case (state_q)
            ST_IDLE: begin
                if (req_ok) begin
                    start = 1'b1;
                end
            end

            ST_SEND: begin
                valid_d = 1'b1;
                data_d  = cur_byte;
                if (byte_cnt_q == LAST_IDX) begin
                    last_d     = 1'b1;
                    state_d    = ST_GAP;
                    gap_cnt_d  = '0;
                    byte_cnt_d = '0;
                    seq_d      = BYTE_W'(seq_q + 8'd1);
                end else begin
                    csum_d     = csum_q ^ cur_byte;
                    byte_cnt_d = CNT_W'(byte_cnt_q + 4'd1);
                end
                if (req_ok) begin
                    pend_d      = 1'b1;
                    shd_delay_d = delay_time;
                    shd_stop_d  = stop_time;
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    // A request arriving on the final gap cycle supersedes the shadow.
                    if (req_ok) begin
                        start = 1'b1;
                    end else if (pend_q) begin
                        start       = 1'b1;
                        start_delay = shd_delay_q;
                        start_stop  = shd_stop_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = GAP_W'(gap_cnt_q + 8'd1);
                    if (req_ok) begin
                        pend_d      = 1'b1;
                        shd_delay_d = delay_time;
                        shd_stop_d  = stop_time;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start) begin
            state_d     = ST_SEND;
            byte_cnt_d  = CNT_W'(1);
            csum_d      = HDR_BYTE;
            data_d      = HDR_BYTE;
            valid_d     = 1'b1;
            frm_delay_d = start_delay;
            frm_stop_d  = start_stop;
            pend_d      = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            csum_q      <= '0;
            seq_q       <= '0;
            frm_delay_q <= '0;
            frm_stop_q  <= '0;
            shd_delay_q <= '0;
            shd_stop_q  <= '0;
            pend_q      <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            csum_q      <= csum_d;
            seq_q       <= seq_d;
            frm_delay_q <= frm_delay_d;
            frm_stop_q  <= frm_stop_d;
            shd_delay_q <= shd_delay_d;
            shd_stop_q  <= shd_stop_d;
            pend_q      <= pend_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign data_out       = data_q;
    assign data_out_valid = valid_q;
    assign last_data      = last_q;
    assign busy           = busy_q;
    assign frame_done     = done_q;
    assign cfg_err        = err_q;
    assign seq_num        = seq_q;

endmodule

// File: tb/tb_gate_cfg_frame_tx.sv
// Bench for gate_cfg_frame_tx: directed frame table, multi-cycle corner sequences
// and random traffic, all checked against a frame-timeline reference model.
module tb_gate_cfg_frame_tx;

    localparam int         IFG = 4;
    localparam logic [7:0] HDR = 8'hBD;

    logic        clk;
    logic        rst;
    logic        send_req;
    logic [31:0] delay_time;
    logic [31:0] stop_time;
    logic [7:0]  data_out;
    logic        data_out_valid;
    logic        last_data;
    logic        busy;
    logic        frame_done;
    logic        cfg_err;
    logic [7:0]  seq_num;

    gate_cfg_frame_tx #(.IFG_CYCLES(IFG), .HDR_BYTE(HDR)) dut (
        .clk(clk), .rst(rst), .send_req(send_req),
        .delay_time(delay_time), .stop_time(stop_time),
        .data_out(data_out), .data_out_valid(data_out_valid),
        .last_data(last_data), .busy(busy), .frame_done(frame_done),
        .cfg_err(cfg_err), .seq_num(seq_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int edge_n = 0;

    // Reference model: one active frame timeline (start edge m_fs) plus a one-deep pending slot.
    bit          m_have, m_pend;
    int          m_fs;
    logic [7:0]  m_seq, m_fseq;
    logic [31:0] m_fd, m_fst, m_sd, m_sst;
    bit          e_valid, e_last, e_done, e_busy, e_err;
    logic [7:0]  e_data, e_seq;

    logic [9:0]  hist[$];

    typedef struct {
        bit          req;
        logic [31:0] d;
        logic [31:0] s;
        bit          ev;
        logic [7:0]  ed;
        bit          el;
        bit          edn;
        bit          eb;
        logic [7:0]  es;
    } vec_t;

    vec_t        tbl [18];
    logic [7:0]  f1  [16];
    int          i15, j2, starts;
    logic [31:0] rd, rs;
    bit          rq, rr;

    function automatic logic [7:0] frame_byte(input int k, input logic [7:0] sq,
                                              input logic [31:0] d, input logic [31:0] s);
        logic [7:0] b [16];
        for (int i = 0; i < 16; i++) b[i] = 8'h00;
        b[0] = HDR;
        b[1] = sq;
        for (int i = 0; i < 4; i++) begin
            b[5 + i] = 8'(d >> (8 * (3 - i)));
            b[9 + i] = 8'(s >> (8 * (3 - i)));
        end
        for (int i = 0; i < 15; i++) b[15] = b[15] ^ b[i];
        return b[k];
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, edge_n, got, exp);
        end
    endtask

    task automatic model_edge(input bit q, input logic [31:0] d, input logic [31:0] s, input bit r);
        bit          ok, start;
        int          k;
        logic [31:0] ud, us;
        if (r) begin
            m_have = 0; m_pend = 0; m_seq = 8'h00;
            e_valid = 0; e_last = 0; e_done = 0; e_busy = 0; e_err = 0;
            e_data = 8'h00; e_seq = 8'h00;
            return;
        end
        ok    = q && (s != 0) && (s > d);
        start = 0;
        ud    = d;
        us    = s;
        if (m_have && edge_n == m_fs + 16 + IFG) begin
            if (ok) start = 1;
            else if (m_pend) begin start = 1; ud = m_sd; us = m_sst; end
        end else if (!m_have || edge_n > m_fs + 16 + IFG) begin
            if (ok) start = 1;
        end else if (ok) begin
            m_pend = 1; m_sd = d; m_sst = s;
        end
        if (start) begin
            m_have = 1; m_fs = edge_n; m_pend = 0;
            m_fseq = m_seq + 8'd1; m_fd = ud; m_fst = us;
        end
        k = m_have ? edge_n - m_fs : 1000;
        if (k == 15) m_seq = m_fseq;
        e_valid = (k <= 15);
        e_data  = e_valid ? frame_byte(k, m_fseq, m_fd, m_fst) : 8'h00;
        e_last  = (k == 15);
        e_done  = (k == 16);
        e_busy  = (k < 16 + IFG);
        e_err   = q && !ok;
        e_seq   = m_seq;
    endtask

    task automatic step(input bit q, input logic [31:0] d, input logic [31:0] s, input bit r);
        send_req   = q;
        delay_time = d;
        stop_time  = s;
        rst        = r;
        @(posedge clk);
        model_edge(q, d, s, r);
        #1;
        chk("m_valid", 32'(data_out_valid), 32'(e_valid));
        chk("m_data",  32'(data_out),       32'(e_data));
        chk("m_last",  32'(last_data),      32'(e_last));
        chk("m_done",  32'(frame_done),     32'(e_done));
        chk("m_busy",  32'(busy),           32'(e_busy));
        chk("m_err",   32'(cfg_err),        32'(e_err));
        chk("m_seq",   32'(seq_num),        32'(e_seq));
        hist.push_back({last_data, data_out_valid, data_out});
        edge_n++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; send_req = 1'b0; delay_time = '0; stop_time = '0;
        repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1);

        // Reference frame with hand-derived bytes (checksum BD^01^50^03^20 = CF).
        f1 = '{8'hBD, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h50, 8'h00, 8'h00, 8'h03, 8'h20, 8'h00, 8'h00, 8'hCF};
        for (int i = 0; i < 16; i++)
            tbl[i] = '{(i == 0), 32'h50, 32'h320, 1'b1, f1[i], (i == 15), 1'b0, 1'b1,
                       (i == 15) ? 8'd1 : 8'd0};
        tbl[16] = '{1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'd1};
        tbl[17] = '{1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd1};
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].req, tbl[i].d, tbl[i].s, 1'b0);
            chk("t_valid", 32'(data_out_valid), 32'(tbl[i].ev));
            chk("t_data",  32'(data_out),       32'(tbl[i].ed));
            chk("t_last",  32'(last_data),      32'(tbl[i].el));
            chk("t_done",  32'(frame_done),     32'(tbl[i].edn));
            chk("t_busy",  32'(busy),           32'(tbl[i].eb));
            chk("t_seq",   32'(seq_num),        32'(tbl[i].es));
        end

        // Follow-on request mid-frame is held through the gap.
        step(1'b0, 32'h0, 32'h0, 1'b1);
        hist.delete();
        step(1'b1, 32'h50, 32'h320, 1'b0);
        idle(6);
        step(1'b1, 32'h11223344, 32'h55667788, 1'b0);
        idle(45);
        i15 = -1; j2 = -1;
        for (int i = 0; i < hist.size(); i++) if (hist[i][9] && i15 < 0) i15 = i;
        for (int i = 0; i < hist.size(); i++) if (i15 >= 0 && i > i15 && hist[i][8] && j2 < 0) j2 = i;
        if (j2 >= 0 && j2 + 15 < hist.size()) begin
            chk("r029_gap", 32'(j2 - i15), 32'(IFG + 1));
            chk("r029_b1",  32'(hist[j2 + 1][7:0]), 32'h02);
            chk("r029_dly", {hist[j2 + 5][7:0], hist[j2 + 6][7:0], hist[j2 + 7][7:0], hist[j2 + 8][7:0]}, 32'h11223344);
            chk("r029_stp", {hist[j2 + 9][7:0], hist[j2 + 10][7:0], hist[j2 + 11][7:0], hist[j2 + 12][7:0]}, 32'h55667788);
        end else begin
            chk("r029_found", 32'(j2), 32'(i15 + IFG + 1));
        end

        // Rejected request: equal open/close counts.
        step(1'b1, 32'd100, 32'd100, 1'b0);
        chk("r030_err",   32'(cfg_err),        32'h1);
        chk("r030_valid", 32'(data_out_valid), 32'h0);
        step(1'b0, 32'h0, 32'h0, 1'b0);
        chk("r030_err1",  32'(cfg_err),        32'h0);
        chk("r030_valid1", 32'(data_out_valid), 32'h0);
        chk("r030_seq",   32'(seq_num),        32'h02);
        idle(3);

        // Three requests while busy collapse to one follow-on frame, last one wins.
        hist.delete();
        step(1'b1, 32'd10, 32'd20, 1'b0);
        idle(3);
        step(1'b1, 32'd5, 32'd500, 1'b0);
        idle(1);
        step(1'b1, 32'd5, 32'd600, 1'b0);
        idle(2);
        step(1'b1, 32'd5, 32'd700, 1'b0);
        idle(50);
        starts = 0; j2 = -1;
        for (int i = 0; i < hist.size(); i++)
            if (hist[i][8] && (i == 0 || !hist[i - 1][8])) begin
                starts++;
                if (starts == 2) j2 = i;
            end
        chk("r031_frames", 32'(starts), 32'd2);
        if (j2 >= 0 && j2 + 15 < hist.size()) begin
            chk("r031_stp", {hist[j2 + 9][7:0], hist[j2 + 10][7:0], hist[j2 + 11][7:0], hist[j2 + 12][7:0]}, 32'd700);
            chk("r031_b1",  32'(hist[j2 + 1][7:0]), 32'h04);
        end else begin
            chk("r031_found", 32'(j2), 32'd1);
        end

        // Reset mid-frame aborts the frame and drops the pending request.
        step(1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b1, 32'h50, 32'h320, 1'b0);
        idle(4);
        step(1'b1, 32'd5, 32'd9, 1'b0);
        idle(3);
        step(1'b0, 32'h0, 32'h0, 1'b1);
        chk("r032_valid", 32'(data_out_valid), 32'h0);
        chk("r032_busy",  32'(busy),           32'h0);
        hist.delete();
        idle(30);
        starts = 0;
        for (int i = 0; i < hist.size(); i++) if (hist[i][8]) starts++;
        chk("r032_quiet", 32'(starts), 32'd0);
        hist.delete();
        step(1'b1, 32'h50, 32'h320, 1'b0);
        idle(2);
        chk("r032_b1", 32'(hist[1][7:0]), 32'h01);
        idle(20);

        // 256 back-to-back frames wrap the sequence number.
        step(1'b0, 32'h0, 32'h0, 1'b1);
        for (int f = 0; f < 256; f++) begin
            if (f == 255) hist.delete();
            rd = 32'($urandom_range(0, 1000000));
            rs = rd + 32'd1 + 32'($urandom_range(0, 1000));
            step(1'b1, rd, rs, 1'b0);
            idle(16 + IFG);
        end
        chk("r033_b1",  32'(hist[1][7:0]), 32'h00);
        chk("r033_seq", 32'(seq_num),      32'h00);

        // Random traffic, including illegal and full-range counts and occasional reset.
        for (int c = 0; c < 4000; c++) begin
            rr = ($urandom_range(0, 299) == 0);
            rq = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 7) == 0) ? 32'($urandom()) : 32'($urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0) rs = 32'($urandom_range(0, rd));
            else rs = rd + 32'd1 + 32'($urandom_range(0, 255));
            step(rq, rd, rs, rr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
